// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front end (skew feeder) and the PE array top.
// SYSTOLIC_CHECK_FRAME_LEN rejects frame lengths too short to hold a fully skewed tile.
`define SYSTOLIC_CHECK_FRAME_LEN(fl, dim) \
  if ((fl) < 2*(dim)-1) begin : g_frame_len_check \
    $error("FRAME_LEN must be at least 2*DIMENSION-1"); \
  end

package systolic_pkg;

  localparam int DEF_DIMENSION = 4;
  localparam int DEF_I_BITS    = 8;
  localparam int LANE_W        = DEF_DIMENSION * DEF_I_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } feeder_state_t;

  function automatic logic [DEF_I_BITS-1:0] lane(input logic [LANE_W-1:0] vec, input int i);
    return vec[i*DEF_I_BITS +: DEF_I_BITS];
  endfunction

endpackage

// File: rtl/skew_tile_bank.sv
// One ping-pong tile buffer: A columns and B rows written by beat index, read back
// as a diagonally skewed slice for a given frame phase (lane i lags by i cycles).
module skew_tile_bank #(
  parameter int DIMENSION = 4,
  parameter int I_BITS    = 8,
  parameter int PH_W      = 3,
  parameter int SLOT_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [SLOT_W-1:0]           wr_slot,
  input  logic [DIMENSION*I_BITS-1:0] a_col,
  input  logic [DIMENSION*I_BITS-1:0] b_row,
  input  logic                        set_full,
  input  logic                        clr_full,
  input  logic [PH_W-1:0]             phase,
  output logic                        full,
  output logic [DIMENSION*I_BITS-1:0] a_skew,
  output logic [DIMENSION*I_BITS-1:0] b_skew
);

  localparam int DATA_W = DIMENSION * I_BITS;

  // a_mem[k] holds column k of A, b_mem[k] holds row k of B, both lane-packed.
  logic [DATA_W-1:0] a_mem [DIMENSION];
  logic [DATA_W-1:0] b_mem [DIMENSION];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      for (int k = 0; k < DIMENSION; k++) begin
        a_mem[k] <= '0;
        b_mem[k] <= '0;
      end
    end else begin
      if (wr_en) begin
        a_mem[wr_slot] <= a_col;
        b_mem[wr_slot] <= b_row;
      end
      if (clr_full) begin
        full <= 1'b0;
      end else if (set_full) begin
        full <= 1'b1;
      end
    end
  end

  // Lane i at phase t carries element k = t - i; outside the window it stays zero.
  always_comb begin
    a_skew = '0;
    b_skew = '0;
    for (int i = 0; i < DIMENSION; i++) begin
      for (int k = 0; k < DIMENSION; k++) begin
        if (phase == PH_W'(i + k)) begin
          a_skew[i*I_BITS +: I_BITS] = a_mem[k][i*I_BITS +: I_BITS];
          b_skew[i*I_BITS +: I_BITS] = b_mem[k][i*I_BITS +: I_BITS];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skew feeder: loads A/B tiles into ping-pong banks and replays them as skewed edge streams
// on a free-running frame grid. Define SKEW_FEEDER_STATS_EN to add o_tile_count and o_underrun.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DIMENSION = DEF_DIMENSION,
  parameter int I_BITS    = DEF_I_BITS,
  parameter int FRAME_LEN = 2 * DIMENSION
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [DIMENSION*I_BITS-1:0] i_a_col,
  input  logic [DIMENSION*I_BITS-1:0] i_b_row,
  output logic [DIMENSION*I_BITS-1:0] o_a,
  output logic [DIMENSION*I_BITS-1:0] o_b,
  output logic                        o_frame_start,
  output logic                        o_busy
`ifdef SKEW_FEEDER_STATS_EN
  ,
  output logic [15:0]                 o_tile_count,
  output logic                        o_underrun
`endif
);

  localparam int DATA_W = DIMENSION * I_BITS;
  localparam int PH_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int SLOT_W = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
  localparam logic [PH_W-1:0]   LAST_PHASE = PH_W'(FRAME_LEN - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(DIMENSION - 1);

  `SYSTOLIC_CHECK_FRAME_LEN(FRAME_LEN, DIMENSION)

  feeder_state_t     state;
  logic [PH_W-1:0]   phase;
  logic [PH_W-1:0]   phase_nxt;
  logic [SLOT_W-1:0] beat;
  logic              rd_bank;
  logic              wr_bank;
  logic              wr_nxt;
  logic              next_bank;
  logic              sel;
  logic              wrap;
  logic              accept;
  logic              last_beat;
  logic              start;
  logic              play_nxt;
  logic [1:0]        full;
  logic [1:0]        wr_en;
  logic [1:0]        set_full;
  logic [1:0]        clr_full;
  logic [DATA_W-1:0] a_skew [2];
  logic [DATA_W-1:0] b_skew [2];

  // Handshake: a beat transfers on a rising edge where i_valid && o_ready; the data
  // must be stable with i_valid, and i_valid may be held across beats and tiles.
  always_comb begin
    wrap      = (phase == LAST_PHASE);
    phase_nxt = wrap ? '0 : phase + 1'b1;
    accept    = i_valid && o_ready && !full[wr_bank];
    last_beat = accept && (beat == LAST_SLOT);
    wr_nxt    = last_beat ? ~wr_bank : wr_bank;
    wr_en     = '0;
    set_full  = '0;
    clr_full  = '0;
    if (accept) wr_en[wr_bank] = 1'b1;
    if (last_beat) set_full[wr_bank] = 1'b1;
    if (state == PLAY && wrap) clr_full[rd_bank] = 1'b1;
    // A bank completing on the wrap edge counts as present, so it plays with no gap.
    next_bank = (state == PLAY) ? ~rd_bank : rd_bank;
    start     = wrap && (full[next_bank] || set_full[next_bank]);
    play_nxt  = wrap ? start : (state == PLAY);
    sel       = wrap ? next_bank : rd_bank;
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    skew_tile_bank #(
      .DIMENSION(DIMENSION),
      .I_BITS   (I_BITS),
      .PH_W     (PH_W),
      .SLOT_W   (SLOT_W)
    ) u_bank (
      .clk     (i_clock),
      .rst_n   (i_reset),
      .wr_en   (wr_en[g]),
      .wr_slot (beat),
      .a_col   (i_a_col),
      .b_row   (i_b_row),
      .set_full(set_full[g]),
      .clr_full(clr_full[g]),
      .phase   (phase_nxt),
      .full    (full[g]),
      .a_skew  (a_skew[g]),
      .b_skew  (b_skew[g])
    );
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state         <= IDLE;
      phase         <= '0;
      beat          <= '0;
      rd_bank       <= 1'b0;
      wr_bank       <= 1'b0;
      o_ready       <= 1'b1;
      o_a           <= '0;
      o_b           <= '0;
      o_frame_start <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      phase   <= phase_nxt;
      wr_bank <= wr_nxt;
      if (accept) begin
        beat <= last_beat ? '0 : beat + 1'b1;
      end
      // A bank released on this edge is only seen as free one cycle later.
      o_ready <= !(full[wr_nxt] || set_full[wr_nxt]);
      if (wrap) begin
        state   <= start ? PLAY : IDLE;
        rd_bank <= next_bank;
      end
      o_a           <= play_nxt ? a_skew[sel] : '0;
      o_b           <= play_nxt ? b_skew[sel] : '0;
      o_frame_start <= start;
      o_busy        <= play_nxt;
    end
  end

`ifdef SKEW_FEEDER_STATS_EN
  logic played;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_tile_count <= '0;
      o_underrun   <= 1'b0;
      played       <= 1'b0;
    end else begin
      if (start) begin
        played <= 1'b1;
        if (o_tile_count != 16'hFFFF) o_tile_count <= o_tile_count + 16'd1;
      end
      if (wrap && state == IDLE && played) o_underrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: tiles are driven over valid/ready, a frame-level model predicts
// each frame's start cycle and skewed lane contents, and a monitor checks every output cycle.
module tb_systolic_skew_feeder;
  import systolic_pkg::*;

  localparam int D  = DEF_DIMENSION;
  localparam int IB = DEF_I_BITS;
  localparam int FL = 2 * D;
  localparam int W  = LANE_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         valid = 1'b0;
  logic [W-1:0] a_col = '0;
  logic [W-1:0] b_row = '0;
  logic         ready;
  logic [W-1:0] o_a;
  logic [W-1:0] o_b;
  logic         frame_start;
  logic         busy;
`ifdef SKEW_FEEDER_STATS_EN
  logic [15:0]  tile_count;
  logic         underrun;
`endif

  systolic_skew_feeder #(.DIMENSION(D), .I_BITS(IB), .FRAME_LEN(FL)) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_valid      (valid),
    .o_ready      (ready),
    .i_a_col      (a_col),
    .i_b_row      (b_row),
    .o_a          (o_a),
    .o_b          (o_b),
    .o_frame_start(frame_start),
    .o_busy       (busy)
`ifdef SKEW_FEEDER_STATS_EN
    ,
    .o_tile_count (tile_count),
    .o_underrun   (underrun)
`endif
  );

  // cycle index since reset release; the frame phase is cyc mod FL
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // scoreboard
  logic [2*W-1:0] exp_q[$];
  int             start_q[$];
  int             last_start = -100;
  int             starts_total = 0;
  int             checks = 0;
  int             errors = 0;
  logic [IB-1:0]  ta [D][D];
  logic [IB-1:0]  tbm [D][D];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // reference: tile playable from the first phase-0 cycle after its last beat, FIFO behind the previous frame
  task automatic model_push(input int acc);
    int s;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    s = ((acc / FL) + 1) * FL;
    if (s < last_start + FL) s = last_start + FL;
    last_start = s;
    starts_total++;
    start_q.push_back(s);
    for (int t = 0; t < FL; t++) begin
      av = '0;
      bv = '0;
      for (int i = 0; i < D; i++) begin
        if (t - i >= 0 && t - i < D) begin
          av[i*IB +: IB] = ta[i][t-i];
          bv[i*IB +: IB] = tbm[t-i][i];
        end
      end
      exp_q.push_back({av, bv});
    end
  endtask

  // driver tasks (called at a falling edge)
  task automatic rand_tile();
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        ta[i][j]  = IB'($urandom);
        tbm[i][j] = IB'($urandom);
      end
  endtask

  task automatic send_tile(input int nbeats);
    int w;
    for (int k = 0; k < nbeats; k++) begin
      valid = 1'b1;
      for (int i = 0; i < D; i++) begin
        a_col[i*IB +: IB] = ta[i][k];
        b_row[i*IB +: IB] = tbm[k][i];
      end
      w = 0;
      while (!ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (!ready) begin
        errors++;
        $display("FAIL ready_timeout beat=%0d actual=0 expected=1", k);
        valid = 1'b0;
        return;
      end
      if (k == D - 1) model_push(cyc);
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_cycle_reached", 64'(cyc >= target), 64'd1);
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while ((cyc % FL) != p && n < 4 * FL) begin
      @(negedge clk);
      n++;
    end
    check("wait_phase_reached", 64'(cyc % FL), 64'(p));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || start_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 64'(n < 200), 64'd1);
  endtask

  task automatic clear_model();
    exp_q.delete();
    start_q.delete();
    last_start   = -100;
    starts_total = 0;
  endtask

  // monitor: consumes expectations whenever the DUT presents frame data
  always @(negedge clk) begin
    int s;
    if (rst_n) begin
      if (frame_start) begin
        if (start_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_start_unexpected cycle=%0d actual=1 expected=0", cyc);
        end else begin
          s = start_q.pop_front();
          check("frame_start_cycle", 64'(cyc), 64'(s));
        end
      end
      if (busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL busy_unexpected cycle=%0d actual=1 expected=0", cyc);
        end else begin
          check("frame_lanes", {o_a, o_b}, exp_q.pop_front());
        end
      end else begin
        check("idle_lanes_zero", {o_a, o_b}, 64'd0);
      end
    end
  end

  initial begin
    int s0;
    repeat (2) @(negedge clk);
    check("reset_o_a", 64'(o_a), 64'd0);
    check("reset_o_b", 64'(o_b), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_frame_start", 64'(frame_start), 64'd0);
    check("reset_ready", 64'(ready), 64'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // identity A scaled by 0x40, B rows numbered 1..16
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        ta[i][j]  = (i == j) ? IB'(8'h40) : '0;
        tbm[i][j] = IB'(i * D + j + 1);
      end
    send_tile(D);
    drain();

    // two tiles back-to-back with valid held: second bank fills, ready drops
    rand_tile();
    send_tile(D);
    rand_tile();
    send_tile(D);
    check("ready_low_both_full", 64'(ready), 64'd0);
    drain();

    // load starting at phase 5
    wait_phase(5);
    rand_tile();
    send_tile(D);
    drain();

    // final beat lands on the frame-end edge of the other bank
    rand_tile();
    send_tile(D);
    wait_cyc(last_start + 4);
    rand_tile();
    send_tile(D);
    check("ready_low_after_release", 64'(ready), 64'd0);
    @(negedge clk);
    check("ready_back_high", 64'(ready), 64'd1);
    drain();

    // reset at t=3 of a frame with the other bank half loaded
    rand_tile();
    send_tile(D);
    s0 = last_start;
    rand_tile();
    send_tile(D / 2);
    wait_cyc(s0 + 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_o_a", 64'(o_a), 64'd0);
    check("midreset_o_b", 64'(o_b), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_frame_start", 64'(frame_start), 64'd0);
    check("midreset_ready", 64'(ready), 64'd1);
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * FL) @(negedge clk);
    rand_tile();
    send_tile(D);
    drain();

    // random tiles with random gaps
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 10)) @(negedge clk);
      rand_tile();
      send_tile(D);
    end
    drain();

`ifdef SKEW_FEEDER_STATS_EN
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("stats_reset_count", 64'(tile_count), 64'd0);
    check("stats_reset_underrun", 64'(underrun), 64'd0);
    for (int n = 0; n < 3; n++) begin
      rand_tile();
      send_tile(D);
    end
    drain();
    repeat (2 * FL) @(negedge clk);
    check("stats_tile_count", 64'(tile_count), 64'(starts_total));
    check("stats_underrun", 64'(underrun), 64'd1);
`endif

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("start_q_empty", 64'(start_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
